// File: rtl/sic1_pkg.sv
// rtl/sic1_pkg.sv - shared constants and encodings for the SIC-1 memory arbiter
package sic1_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // Port identifiers double as bit positions in the request/grant vectors
    localparam logic PORT_C = 1'b0;
    localparam logic PORT_H = 1'b1;

    typedef enum logic {
        LOCK_UNLOCKED = 1'b0,
        LOCK_LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/sic1_rr_pick.sv
// rtl/sic1_rr_pick.sv - combinational two-way picker returning a one-hot grant
module sic1_rr_pick (
    input  logic [1:0] req,
    input  logic       rr_last,
    input  logic       prio_mode,
    input  logic       force_h,
    output logic [1:0] gnt
);
    import sic1_pkg::*;

    always_comb begin
        gnt = 2'b00;
        if (force_h && req[PORT_H]) begin
            gnt[PORT_H] = 1'b1;
        end else if (req == 2'b11) begin
            // Tie: host priority, otherwise the port that did not win last
            if (prio_mode || (rr_last == PORT_C)) begin
                gnt[PORT_H] = 1'b1;
            end else begin
                gnt[PORT_C] = 1'b1;
            end
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/sic1_mem_arbiter.sv
// rtl/sic1_mem_arbiter.sv - shares the SIC-1 memory port between CPU and host
module sic1_mem_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int ADDR_W   = sic1_pkg::ADDR_W,
    parameter int DATA_W   = sic1_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prio_mode,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    input  logic              h_lock,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);
    import sic1_pkg::*;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    lock_state_t lock_state;
    lock_state_t lock_next;
    logic [3:0]  hold_cnt;
    logic [3:0]  hold_next;
    logic        rr_last;
    logic        rd_valid;
    logic        rd_owner;

    logic        lock_active;
    logic        hold_full;
    logic        force_h;
    logic        force_c;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        any_gnt;
    logic        sel_h;
    logic        sel_we;

    assign lock_active = (lock_state == LOCK_LOCKED);
    assign hold_full   = (hold_cnt >= HOLD_MAX);
    assign force_h     = lock_active && h_req && !hold_full;
    // Once the host has used up its hold budget the CPU gets one slot
    assign force_c     = lock_active && hold_full && c_req;
    assign req         = {h_req & ~force_c, c_req};

    sic1_rr_pick u_pick (
        .req       (req),
        .rr_last   (rr_last),
        .prio_mode (prio_mode),
        .force_h   (force_h),
        .gnt       (gnt)
    );

    assign c_gnt   = gnt[PORT_C];
    assign h_gnt   = gnt[PORT_H];
    assign any_gnt = |gnt;
    assign sel_h   = gnt[PORT_H];
    assign sel_we  = sel_h ? h_we : c_we;
    assign busy    = rd_valid;

    always_comb begin
        lock_next = lock_state;
        hold_next = hold_cnt;
        case (lock_state)
            LOCK_UNLOCKED: if (h_gnt && h_lock) lock_next = LOCK_LOCKED;
            LOCK_LOCKED:   if (!h_lock || !h_req) lock_next = LOCK_UNLOCKED;
            default:       lock_next = LOCK_UNLOCKED;
        endcase
        // The grant that takes the lock already counts against the budget
        if (c_gnt || (lock_next == LOCK_UNLOCKED)) begin
            hold_next = 4'd0;
        end else if (h_gnt && c_req && !hold_full) begin
            hold_next = hold_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_state <= LOCK_UNLOCKED;
            hold_cnt   <= 4'd0;
            rr_last    <= PORT_H;
        end else begin
            lock_state <= lock_next;
            hold_cnt   <= hold_next;
            if (any_gnt) begin
                rr_last <= sel_h ? PORT_H : PORT_C;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr    <= '0;
            mem_data_in <= '0;
            mem_wr_en   <= 1'b0;
            rd_valid    <= 1'b0;
            rd_owner    <= PORT_C;
        end else begin
            mem_wr_en <= any_gnt && sel_we;
            rd_valid  <= any_gnt && !sel_we;
            if (any_gnt) begin
                mem_addr    <= sel_h ? h_addr : c_addr;
                mem_data_in <= sel_h ? h_wdata : c_wdata;
                rd_owner    <= sel_h ? PORT_H : PORT_C;
            end
        end
    end

    // Read data is captured in the cycle after the address was presented
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_rvalid <= 1'b0;
            h_rvalid <= 1'b0;
            c_rdata  <= '0;
            h_rdata  <= '0;
        end else begin
            c_rvalid <= rd_valid && (rd_owner == PORT_C);
            h_rvalid <= rd_valid && (rd_owner == PORT_H);
            if (rd_valid && (rd_owner == PORT_C)) c_rdata <= mem_data_out;
            if (rd_valid && (rd_owner == PORT_H)) h_rdata <= mem_data_out;
        end
    end

endmodule

// File: tb/tb_sic1_mem_arbiter.sv
// tb/tb_sic1_mem_arbiter.sv - directed self-checking bench for sic1_mem_arbiter
module tb_sic1_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       prio_mode = 1'b0;
    logic       c_req = 1'b0;
    logic       c_we = 1'b0;
    logic [7:0] c_addr = 8'h00;
    logic [7:0] c_wdata = 8'h00;
    logic       c_gnt;
    logic       c_rvalid;
    logic [7:0] c_rdata;
    logic       h_req = 1'b0;
    logic       h_we = 1'b0;
    logic [7:0] h_addr = 8'h00;
    logic [7:0] h_wdata = 8'h00;
    logic       h_lock = 1'b0;
    logic       h_gnt;
    logic       h_rvalid;
    logic [7:0] h_rdata;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;
    logic       busy;

    logic [7:0] mem [256] = '{16: 8'h5A, default: 8'h00};

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_data_in;
    end
    assign mem_data_out = mem[mem_addr];

    sic1_mem_arbiter #(.MAX_HOLD(4), .ADDR_W(8), .DATA_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .prio_mode    (prio_mode),
        .c_req        (c_req),
        .c_we         (c_we),
        .c_addr       (c_addr),
        .c_wdata      (c_wdata),
        .c_gnt        (c_gnt),
        .c_rvalid     (c_rvalid),
        .c_rdata      (c_rdata),
        .h_req        (h_req),
        .h_we         (h_we),
        .h_addr       (h_addr),
        .h_wdata      (h_wdata),
        .h_lock       (h_lock),
        .h_gnt        (h_gnt),
        .h_rvalid     (h_rvalid),
        .h_rdata      (h_rdata),
        .mem_addr     (mem_addr),
        .mem_wr_en    (mem_wr_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        prio_mode = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_addr = 8'h00; c_wdata = 8'h00;
        h_req = 1'b0; h_we = 1'b0; h_addr = 8'h00; h_wdata = 8'h00;
        h_lock = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int hk;
        logic g_h;
        logic exp_c;

        do_reset();
        check("rst_mem_addr", mem_addr, 8'h00);
        check("rst_wr_en", mem_wr_en, 1'b0);
        check("rst_data_in", mem_data_in, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_rvalid", {c_rvalid, h_rvalid}, 2'b00);
        check("rst_rdata", {c_rdata, h_rdata}, 16'h0000);

        // Single CPU read of 0x10
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10;
        @(negedge clk);
        check("t1_c_gnt", c_gnt, 1'b1);
        check("t1_h_gnt", h_gnt, 1'b0);
        step();
        c_req = 1'b0;
        check("t1_mem_addr", mem_addr, 8'h10);
        check("t1_wr_en", mem_wr_en, 1'b0);
        check("t1_busy", busy, 1'b1);
        check("t1_rvalid_early", c_rvalid, 1'b0);
        step();
        check("t1_c_rvalid", c_rvalid, 1'b1);
        check("t1_c_rdata", c_rdata, 8'h5A);
        check("t1_h_rvalid", h_rvalid, 1'b0);
        step();
        check("t1_rvalid_pulse", c_rvalid, 1'b0);
        check("t1_rdata_hold", c_rdata, 8'h5A);

        // Round-robin tie, C first after reset
        do_reset();
        c_req = 1'b1; h_req = 1'b1; c_addr = 8'h01; h_addr = 8'h02;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("rr_c_%0d", i), c_gnt, (i % 2 == 0) ? 1'b1 : 1'b0);
            check($sformatf("rr_h_%0d", i), h_gnt, (i % 2 == 1) ? 1'b1 : 1'b0);
            step();
        end

        // Host fixed priority
        prio_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("prio_h_%0d", i), h_gnt, 1'b1);
            check($sformatf("prio_c_%0d", i), c_gnt, 1'b0);
            step();
        end

        // Host lock burst with CPU contending
        do_reset();
        prio_mode = 1'b1;
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'h00;
        h_req = 1'b1; h_we = 1'b1; h_lock = 1'b1; h_addr = 8'h20; h_wdata = 8'hA0;
        hk = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_c = (i == 4 || i == 9);
            check($sformatf("lock_c_%0d", i), c_gnt, exp_c);
            check($sformatf("lock_h_%0d", i), h_gnt, !exp_c);
            g_h = h_gnt;
            step();
            if (g_h) begin
                hk++;
                if (hk == 8) begin
                    h_req = 1'b0; h_lock = 1'b0; h_we = 1'b0;
                end else begin
                    h_addr = 8'h20 + 8'(hk);
                    h_wdata = 8'hA0 + 8'(hk);
                end
            end
        end
        c_req = 1'b0;
        step();
        step();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("lock_mem_%0d", k), mem[8'h20 + k], 8'hA0 + k);
        end

        // Host write then CPU read of the same address
        prio_mode = 1'b0;
        h_req = 1'b1; h_we = 1'b1; h_addr = 8'h30; h_wdata = 8'h77;
        @(negedge clk);
        check("raw_h_gnt", h_gnt, 1'b1);
        step();
        h_req = 1'b0; h_we = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'h30;
        check("raw_wr_en_hi", mem_wr_en, 1'b1);
        check("raw_mem_data_in", mem_data_in, 8'h77);
        @(negedge clk);
        check("raw_c_gnt", c_gnt, 1'b1);
        step();
        c_req = 1'b0;
        check("raw_wr_en_lo", mem_wr_en, 1'b0);
        step();
        check("raw_c_rvalid", c_rvalid, 1'b1);
        check("raw_c_rdata", c_rdata, 8'h77);

        // Reset while a read is in flight
        step();
        c_req = 1'b1; c_addr = 8'h10;
        @(negedge clk);
        check("mid_c_gnt", c_gnt, 1'b1);
        step();
        c_req = 1'b0;
        check("mid_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_busy", busy, 1'b0);
        check("mid_mem_addr", mem_addr, 8'h00);
        check("mid_rdata", c_rdata, 8'h00);
        step();
        check("mid_no_rvalid", {c_rvalid, h_rvalid}, 2'b00);
        step();
        check("mid_no_rvalid2", {c_rvalid, h_rvalid}, 2'b00);
        check("mid_wr_en", mem_wr_en, 1'b0);
        c_req = 1'b1; h_req = 1'b1;
        @(negedge clk);
        check("mid_tie_c", c_gnt, 1'b1);
        check("mid_tie_h", h_gnt, 1'b0);
        step();
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
